mem_responder: RTL and testbench

- Memory-side responder for the core's two request ports: instruction fetch (ifu) and load/store (lsu).
- Accepts single-cycle or held `reqValid` requests, arbitrates a single-port word memory, and returns one-cycle `respValid` pulses after a programmable latency.
- Sits below the core control FSM in the SoC and serves as both the simulation memory and the template for a real bus bridge.

---
 rtl/mem_responder_if.sv | 30 +++
 rtl/mem_responder.sv | 236 +++++++++++++++++++++++
 tb/tb_mem_responder.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response bundle between the core's two memory ports and mem_responder.
// The master modport is the core side. The slave modport is the responder side.
interface mem_responder_if;
    logic        ifu_reqValid;
    logic [31:0] ifu_addr;
    logic        ifu_respValid;
    logic [31:0] ifu_rdata;

    logic        lsu_reqValid;
    logic        lsu_wen;
    logic [1:0]  lsu_size;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_respValid;
    logic [31:0] lsu_rdata;

    modport master (
        output ifu_reqValid, ifu_addr,
        output lsu_reqValid, lsu_wen, lsu_size, lsu_addr, lsu_wdata,
        input  ifu_respValid, ifu_rdata,
        input  lsu_respValid, lsu_rdata
    );

    modport slave (
        input  ifu_reqValid, ifu_addr,
        input  lsu_reqValid, lsu_wen, lsu_size, lsu_addr, lsu_wdata,
        output ifu_respValid, ifu_rdata,
        output lsu_respValid, lsu_rdata
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: single-port word memory serving the ifu and lsu request ports.
// Each port captures one request into a pending slot. Arbitration uses fixed
// priority, with lsu ahead of ifu. A one-cycle respValid pulse follows after
// LATENCY cycles.
// Optional feature: define MEM_RESP_JITTER_EN to add 0..7 LFSR-driven extra
// cycles to each access.
module mem_responder #(
    parameter int DEPTH   = 4096,
    parameter int LATENCY = 2,
    parameter int LAT_W   = 4
) (
    input  logic           clock,
    input  logic           reset,
    mem_responder_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

    // Byte-enable lanes for a store. Half ignores addr[0]. Word and size 3 use all lanes.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            2'd0:    be = 4'b0001 << lo;
            2'd1:    be = lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate right-aligned store data into every lane it could target.
    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] d;
        case (size)
            2'd0:    d = {4{wd[7:0]}};
            2'd1:    d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    // Pick the addressed lane(s) of a word. The result is right-aligned and zero-extended.
    function automatic logic [31:0] load_extract(input logic [1:0] size, input logic [1:0] lo,
                                                 input logic [31:0] w);
        logic [31:0] d;
        case (size)
            2'd0: begin
                case (lo)
                    2'd0:    d = {24'h000000, w[7:0]};
                    2'd1:    d = {24'h000000, w[15:8]};
                    2'd2:    d = {24'h000000, w[23:16]};
                    default: d = {24'h000000, w[31:24]};
                endcase
            end
            2'd1:    d = lo[1] ? {16'h0000, w[31:16]} : {16'h0000, w[15:0]};
            default: d = w;
        endcase
        return d;
    endfunction

    logic [31:0]      mem_r [DEPTH];
    state_t           state_r, state_next_s;
    logic [LAT_W-1:0] cnt_r, cnt_load_s;
    logic             sel_r, next_sel_s, start_s;   // sel: 1 = lsu, 0 = ifu
    logic             ifu_pend_r, lsu_pend_r;
    logic [31:0]      ifu_addr_r, lsu_addr_r, lsu_wdata_r;
    logic             lsu_wen_r;
    logic [1:0]       lsu_size_r;
    logic             ifu_resp_r, lsu_resp_r;
    logic [31:0]      ifu_rdata_r, lsu_rdata_r;

    logic             ifu_cap_s, lsu_cap_s, access_s, in_range_s, wr_en_s;
    logic [31:0]      acc_addr_s, rd_word_s, wr_data_s;
    logic [IDX_W-1:0] acc_idx_s;
    logic [3:0]       wr_be_s;

    // A port captures only when its slot is free and it is not being answered.
    // The respValid term keeps a held request from being re-captured on the
    // edge that ends its own response.
    always_comb begin
        ifu_cap_s = bus.ifu_reqValid && !ifu_pend_r && !ifu_resp_r
                    && !((state_r != IDLE) && !sel_r);
        lsu_cap_s = bus.lsu_reqValid && !lsu_pend_r && !lsu_resp_r
                    && !((state_r != IDLE) && sel_r);
    end

`ifdef MEM_RESP_JITTER_EN
    logic [15:0] lfsr_r;

    // Fibonacci LFSR, taps 16,14,13,11, free-running.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr_r <= 16'hACE1;
        end else begin
            lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
        end
    end

    // The counter load adds 0..7 extra cycles taken from the LFSR.
    always_comb begin
        cnt_load_s = LAT_W'(LATENCY - 1) + LAT_W'(lfsr_r[2:0]);
    end
`else
    // Fixed latency: the counter always loads LATENCY-1.
    always_comb begin
        cnt_load_s = LAT_W'(LATENCY - 1);
    end
`endif

    // Next-state logic. RESP hands straight over to the other port when it is
    // pending or capturing this edge, so there is no idle bubble.
    always_comb begin
        state_next_s = state_r;
        start_s      = 1'b0;
        next_sel_s   = sel_r;
        case (state_r)
            IDLE: begin
                if (lsu_pend_r || lsu_cap_s) begin
                    start_s = 1'b1; next_sel_s = 1'b1; state_next_s = BUSY;
                end else if (ifu_pend_r || ifu_cap_s) begin
                    start_s = 1'b1; next_sel_s = 1'b0; state_next_s = BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == '0) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = BUSY;
                end
            end
            RESP: begin
                if (sel_r && (ifu_pend_r || ifu_cap_s)) begin
                    start_s = 1'b1; next_sel_s = 1'b0; state_next_s = BUSY;
                end else if (!sel_r && (lsu_pend_r || lsu_cap_s)) begin
                    start_s = 1'b1; next_sel_s = 1'b1; state_next_s = BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Decode the access for the selected port. Out-of-range indices read 0 and never write.
    always_comb begin
        access_s   = (state_r == BUSY) && (cnt_r == '0);
        acc_addr_s = sel_r ? lsu_addr_r : ifu_addr_r;
        acc_idx_s  = acc_addr_s[IDX_W+1:2];
        in_range_s = ({2'b00, acc_addr_s[31:2]} < 32'(DEPTH));
        if (in_range_s) begin
            rd_word_s = mem_r[acc_idx_s];
        end else begin
            rd_word_s = 32'h0000_0000;
        end
        wr_en_s   = access_s && sel_r && lsu_wen_r && in_range_s && !reset;
        wr_be_s   = byte_en(lsu_size_r, lsu_addr_r[1:0]);
        wr_data_s = lane_data(lsu_size_r, lsu_wdata_r);
    end

    // Storage array, not reset. Byte-enabled write on the edge entering RESP.
    always_ff @(posedge clock) begin
        if (wr_en_s) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be_s[b]) begin
                    mem_r[acc_idx_s][8*b +: 8] <= wr_data_s[8*b +: 8];
                end
            end
        end
    end

    // Request capture, pending slots, latency counter and registered responses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sel_r       <= 1'b0;
            cnt_r       <= '0;
            ifu_pend_r  <= 1'b0;
            lsu_pend_r  <= 1'b0;
            ifu_addr_r  <= 32'h0000_0000;
            lsu_addr_r  <= 32'h0000_0000;
            lsu_wdata_r <= 32'h0000_0000;
            lsu_wen_r   <= 1'b0;
            lsu_size_r  <= 2'd0;
            ifu_resp_r  <= 1'b0;
            lsu_resp_r  <= 1'b0;
            ifu_rdata_r <= 32'h0000_0000;
            lsu_rdata_r <= 32'h0000_0000;
        end else begin
            if (ifu_cap_s) begin
                ifu_addr_r <= bus.ifu_addr;
                ifu_pend_r <= 1'b1;
            end else if (state_r == RESP && !sel_r) begin
                ifu_pend_r <= 1'b0;
            end
            if (lsu_cap_s) begin
                lsu_addr_r  <= bus.lsu_addr;
                lsu_wdata_r <= bus.lsu_wdata;
                lsu_wen_r   <= bus.lsu_wen;
                lsu_size_r  <= bus.lsu_size;
                lsu_pend_r  <= 1'b1;
            end else if (state_r == RESP && sel_r) begin
                lsu_pend_r <= 1'b0;
            end
            if (start_s) begin
                sel_r <= next_sel_s;
                cnt_r <= cnt_load_s;
            end else if (state_r == BUSY && cnt_r != '0) begin
                cnt_r <= cnt_r - LAT_W'(1);
            end
            ifu_resp_r <= access_s && !sel_r;
            lsu_resp_r <= access_s && sel_r;
            if (access_s && sel_r) begin
                lsu_rdata_r <= lsu_wen_r ? 32'h0000_0000
                                         : load_extract(lsu_size_r, lsu_addr_r[1:0], rd_word_s);
            end
            if (access_s && !sel_r) begin
                ifu_rdata_r <= rd_word_s;
            end
        end
    end

    assign bus.ifu_respValid = ifu_resp_r;
    assign bus.ifu_rdata     = ifu_rdata_r;
    assign bus.lsu_respValid = lsu_resp_r;
    assign bus.lsu_rdata     = lsu_rdata_r;
endmodule

// File: tb/tb_mem_responder.sv
// Directed testbench for mem_responder. A vector table of lsu loads/stores is
// followed by hand sequences: held fetch, contention, store handoff and reset in BUSY.
module tb_mem_responder;
    localparam int DEPTH   = 4096;
    localparam int LATENCY = 2;
    // Negedges from driving a request to seeing its respValid.
    localparam int LAT_MIN = LATENCY + 1;
`ifdef MEM_RESP_JITTER_EN
    localparam int LAT_MAX = LATENCY + 1 + 7;
`else
    localparam int LAT_MAX = LATENCY + 1;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    mem_responder_if bus();

    mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY), .LAT_W(4)) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wen;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[20];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Single pulsed lsu request. Returns rdata and negedges to respValid (-1 on timeout).
    task automatic lsu_op(input logic wen, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata, output int lat);
        @(negedge clock);
        bus.lsu_reqValid = 1'b1; bus.lsu_wen = wen; bus.lsu_size = size;
        bus.lsu_addr = addr; bus.lsu_wdata = wdata;
        lat = -1; rdata = 32'h0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (i == 1) bus.lsu_reqValid = 1'b0;
            if (bus.lsu_respValid) begin
                lat = i; rdata = bus.lsu_rdata;
                break;
            end
        end
    endtask

    // Single pulsed ifu request.
    task automatic ifu_op(input logic [31:0] addr, output logic [31:0] rdata, output int lat);
        @(negedge clock);
        bus.ifu_reqValid = 1'b1; bus.ifu_addr = addr;
        lat = -1; rdata = 32'h0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (i == 1) bus.ifu_reqValid = 1'b0;
            if (bus.ifu_respValid) begin
                lat = i; rdata = bus.ifu_rdata;
                break;
            end
        end
    endtask

    // Hard stop if anything hangs.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int lat, cnt, idx, lsu_i, ifu_i, both, t0, lsu_cnt, ifu_cnt;
        logic [31:0] lsu_d, ifu_d;
        logic fired;

        vecs[0]  = '{1'b1, 2'd2, 32'h0000_0000, 32'h0F0F_0F0F, 32'h0000_0000};
        vecs[1]  = '{1'b1, 2'd2, 32'h0000_4000, 32'h5555_5555, 32'h0000_0000};
        vecs[2]  = '{1'b0, 2'd2, 32'h0000_0000, 32'h0,         32'h0F0F_0F0F};
        vecs[3]  = '{1'b0, 2'd2, 32'h0000_4000, 32'h0,         32'h0000_0000};
        vecs[4]  = '{1'b0, 2'd1, 32'hFFFF_FFFE, 32'h0,         32'h0000_0000};
        vecs[5]  = '{1'b1, 2'd2, 32'h0000_0020, 32'h1122_3344, 32'h0000_0000};
        vecs[6]  = '{1'b1, 2'd0, 32'h0000_0021, 32'h0000_00A5, 32'h0000_0000};
        vecs[7]  = '{1'b0, 2'd2, 32'h0000_0020, 32'h0,         32'h1122_A544};
        vecs[8]  = '{1'b0, 2'd1, 32'h0000_0022, 32'h0,         32'h0000_1122};
        vecs[9]  = '{1'b0, 2'd1, 32'h0000_0020, 32'h0,         32'h0000_A544};
        vecs[10] = '{1'b0, 2'd0, 32'h0000_0021, 32'h0,         32'h0000_00A5};
        vecs[11] = '{1'b0, 2'd0, 32'h0000_0023, 32'h0,         32'h0000_0011};
        vecs[12] = '{1'b1, 2'd2, 32'h0000_0024, 32'h0000_0000, 32'h0000_0000};
        vecs[13] = '{1'b1, 2'd1, 32'h0000_0027, 32'h1234_BEEF, 32'h0000_0000};
        vecs[14] = '{1'b0, 2'd2, 32'h0000_0024, 32'h0,         32'hBEEF_0000};
        vecs[15] = '{1'b1, 2'd3, 32'h0000_002B, 32'hCAFE_F00D, 32'h0000_0000};
        vecs[16] = '{1'b0, 2'd0, 32'h0000_002A, 32'h0,         32'h0000_00FE};
        vecs[17] = '{1'b0, 2'd3, 32'h0000_0028, 32'h0,         32'hCAFE_F00D};
        vecs[18] = '{1'b1, 2'd2, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000};
        vecs[19] = '{1'b1, 2'd2, 32'h0000_0040, 32'h1357_9BDF, 32'h0000_0000};

        bus.ifu_reqValid = 1'b0; bus.ifu_addr = 32'h0;
        bus.lsu_reqValid = 1'b0; bus.lsu_wen = 1'b0; bus.lsu_size = 2'd0;
        bus.lsu_addr = 32'h0; bus.lsu_wdata = 32'h0;

        // Reset state.
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check32("reset_ifu_resp", {31'h0, bus.ifu_respValid}, 32'h0);
        check32("reset_lsu_resp", {31'h0, bus.lsu_respValid}, 32'h0);
        check32("reset_ifu_rdata", bus.ifu_rdata, 32'h0);
        check32("reset_lsu_rdata", bus.lsu_rdata, 32'h0);

        // Vector table: lsu loads and stores.
        for (int v = 0; v < 20; v++) begin
            lsu_op(vecs[v].wen, vecs[v].size, vecs[v].addr, vecs[v].wdata, rd, lat);
            check32($sformatf("vec%0d_rdata", v), rd, vecs[v].exp);
            check_rng($sformatf("vec%0d_latency", v), lat, LAT_MIN, LAT_MAX);
        end

        // IFU basic: request held until its response. Expect exactly one pulse.
        @(negedge clock);
        bus.ifu_reqValid = 1'b1; bus.ifu_addr = 32'h0000_0010;
        cnt = 0; idx = -1; ifu_d = 32'h0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (bus.ifu_respValid) begin
                cnt++;
                if (idx < 0) begin idx = i; ifu_d = bus.ifu_rdata; end
                bus.ifu_reqValid = 1'b0;
            end
        end
        check_rng("ifu_held_latency", idx, LAT_MIN, LAT_MAX);
        check32("ifu_held_rdata", ifu_d, 32'hDEAD_BEEF);
        check_rng("ifu_held_pulses", cnt, 1, 1);
        check32("ifu_rdata_hold", bus.ifu_rdata, 32'hDEAD_BEEF);

        // Contention: lsu is served first, then ifu LATENCY+1 cycles later.
        @(negedge clock);
        bus.ifu_reqValid = 1'b1; bus.ifu_addr = 32'h0000_0010;
        bus.lsu_reqValid = 1'b1; bus.lsu_wen = 1'b0; bus.lsu_size = 2'd2;
        bus.lsu_addr = 32'h0000_0020;
        lsu_i = -1; ifu_i = -1; both = 0; lsu_d = 32'h0; ifu_d = 32'h0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clock);
            if (i == 1) begin bus.ifu_reqValid = 1'b0; bus.lsu_reqValid = 1'b0; end
            if (bus.lsu_respValid && lsu_i < 0) begin lsu_i = i; lsu_d = bus.lsu_rdata; end
            if (bus.ifu_respValid && ifu_i < 0) begin ifu_i = i; ifu_d = bus.ifu_rdata; end
            if (bus.lsu_respValid && bus.ifu_respValid) both++;
        end
        check_rng("contend_lsu_latency", lsu_i, LAT_MIN, LAT_MAX);
        check_rng("contend_ifu_after_lsu", ifu_i - lsu_i, LAT_MIN, LAT_MAX);
        check_rng("contend_overlap", both, 0, 0);
        check32("contend_lsu_rdata", lsu_d, 32'h1122_A544);
        check32("contend_ifu_rdata", ifu_d, 32'hDEAD_BEEF);

        // Store handoff: ifu rises during the lsu response cycle.
        @(negedge clock);
        bus.lsu_reqValid = 1'b1; bus.lsu_wen = 1'b1; bus.lsu_size = 2'd2;
        bus.lsu_addr = 32'h0000_0030; bus.lsu_wdata = 32'h0BAD_F00D;
        fired = 1'b0; t0 = 0; lsu_cnt = 0; ifu_cnt = 0; ifu_i = -1; ifu_d = 32'h0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clock);
            if (fired && i == t0 + 1) bus.ifu_reqValid = 1'b0;
            if (bus.ifu_respValid) begin
                ifu_cnt++; ifu_i = i; ifu_d = bus.ifu_rdata;
            end
            if (bus.lsu_respValid) begin
                lsu_cnt++;
                if (!fired) begin
                    bus.lsu_reqValid = 1'b0;
                    bus.ifu_reqValid = 1'b1; bus.ifu_addr = 32'h0000_0030;
                    fired = 1'b1; t0 = i;
                end
            end
        end
        check_rng("handoff_store_pulses", lsu_cnt, 1, 1);
        check_rng("handoff_fetch_pulses", ifu_cnt, 1, 1);
        check_rng("handoff_fetch_latency", ifu_i - t0, LAT_MIN, LAT_MAX);
        check32("handoff_fetch_rdata", ifu_d, 32'h0BAD_F00D);

        // Reset in BUSY: the store is dropped, outputs clear, and no response follows.
        lsu_op(1'b0, 2'd2, 32'h0000_0040, 32'h0, rd, lat);
        check32("pre_reset_load", rd, 32'h1357_9BDF);
        @(negedge clock);
        bus.lsu_reqValid = 1'b1; bus.lsu_wen = 1'b1; bus.lsu_size = 2'd2;
        bus.lsu_addr = 32'h0000_0040; bus.lsu_wdata = 32'hFFFF_FFFF;
        @(negedge clock);
        bus.lsu_reqValid = 1'b0;
        reset = 1'b1;
        #1;
        check32("busy_reset_lsu_rdata", bus.lsu_rdata, 32'h0);
        check32("busy_reset_ifu_rdata", bus.ifu_rdata, 32'h0);
        check32("busy_reset_lsu_resp", {31'h0, bus.lsu_respValid}, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        cnt = 0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clock);
            if (bus.lsu_respValid || bus.ifu_respValid) cnt++;
        end
        check_rng("busy_reset_no_resp", cnt, 0, 0);
        lsu_op(1'b0, 2'd2, 32'h0000_0040, 32'h0, rd, lat);
        check32("busy_reset_word_kept", rd, 32'h1357_9BDF);

`ifdef MEM_RESP_JITTER_EN
        // Jitter: back-to-back fetches, each within the widened latency window.
        for (int n = 0; n < 200; n++) begin
            ifu_op(32'h0000_0010, rd, lat);
            check_rng($sformatf("jitter%0d_latency", n), lat, LAT_MIN, LAT_MAX);
            check32($sformatf("jitter%0d_rdata", n), rd, 32'hDEAD_BEEF);
        end
`else
        ifu_op(32'h0000_0020, rd, lat);
        check32("final_fetch_rdata", rd, 32'h1122_A544);
        check_rng("final_fetch_latency", lat, LAT_MIN, LAT_MAX);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
